// File: rtl/fp32_subtractor_if.sv
// Operand/result handshake bundle for the FP32 subtractor.
// Master drives operands and out_ready; slave returns in_ready, out_valid and Result.
interface fp32_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Result
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Result
  );
endinterface

// File: rtl/fp32_subtractor.sv
// FP32 Result = A - B (denormals flushed, RNE), 3-stage pipe on the falling edge of clk_n.
// Latency 3 edges; one op per cycle; all stages stall together when Result is held unconsumed.
module fp32_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk_n,
  input  logic             rst_n,
  fp32_subtractor_if.slave io
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic        vld;
    logic        sign;
    logic [7:0]  exp;
    logic [7:0]  diff;
    logic [23:0] big_man;
    logic [23:0] small_man;
    logic        sub;
    logic        spec;
    logic [31:0] spec_val;
  } s1_t;

  typedef struct packed {
    logic        vld;
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] sum;
    logic        spec;
    logic [31:0] spec_val;
  } s2_t;

  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;
  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] result_d, result_q;
  logic             advance;

  assign advance      = ~out_valid_q | io.out_ready;
  assign io.in_ready  = advance;
  assign io.out_valid = out_valid_q;
  assign io.Result    = result_q;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       hit;
    n   = 5'd0;
    hit = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!hit && v[i]) hit = 1'b1;
      else if (!hit)    n = n + 5'd1;
    end
    return n;
  endfunction

  // ---------------- stage 1: unpack, classify, swap ----------------
  logic        a_sign, b_sign;
  logic [7:0]  a_exp, b_exp;
  logic [22:0] a_frac, b_frac;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [30:0] a_mag, b_mag;
  logic        swap, eff_sub;

  always_comb begin
    a_sign  = io.A[31];
    b_sign  = ~io.B[31];
    a_exp   = io.A[30:23];
    b_exp   = io.B[30:23];
    a_frac  = (a_exp == 8'd0) ? 23'd0 : io.A[22:0];
    b_frac  = (b_exp == 8'd0) ? 23'd0 : io.B[22:0];
    a_nan   = (a_exp == 8'hFF) && (io.A[22:0] != 23'd0);
    b_nan   = (b_exp == 8'hFF) && (io.B[22:0] != 23'd0);
    a_inf   = (a_exp == 8'hFF) && (io.A[22:0] == 23'd0);
    b_inf   = (b_exp == 8'hFF) && (io.B[22:0] == 23'd0);
    a_mag   = {a_exp, a_frac};
    b_mag   = {b_exp, b_frac};
    swap    = b_mag > a_mag;
    eff_sub = a_sign ^ b_sign;

    s1_d           = '0;
    s1_d.vld       = io.in_valid;
    s1_d.sign      = swap ? b_sign : a_sign;
    s1_d.exp       = swap ? b_exp : a_exp;
    s1_d.diff      = swap ? (b_exp - a_exp) : (a_exp - b_exp);
    s1_d.big_man   = swap ? {b_exp != 8'd0, b_frac} : {a_exp != 8'd0, a_frac};
    s1_d.small_man = swap ? {a_exp != 8'd0, a_frac} : {b_exp != 8'd0, b_frac};
    s1_d.sub       = eff_sub;

    // Special outcomes are decided here and ride the pipe as a finished word.
    if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = QNAN;
    end else if (a_inf) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = {a_sign, 8'hFF, 23'd0};
    end else if (b_inf) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = {b_sign, 8'hFF, 23'd0};
    end else if ((a_mag == b_mag) && eff_sub) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = 32'h0000_0000;
    end else if ((a_mag == 31'd0) && (b_mag == 31'd0)) begin
      // Only same-signed zeros reach here: keeps (-0) - (+0) negative.
      s1_d.spec     = 1'b1;
      s1_d.spec_val = {a_sign, 31'd0};
    end
  end

  // ---------------- stage 2: align and add/subtract ----------------
  logic [4:0]  sh;
  logic [26:0] small_ext, big_ext, aligned, shift_mask;

  always_comb begin
    sh         = (s1_q.diff > 8'd26) ? 5'd26 : s1_q.diff[4:0];
    small_ext  = {s1_q.small_man, 3'b000};
    big_ext    = {s1_q.big_man, 3'b000};
    shift_mask = (27'd1 << sh) - 27'd1;
    aligned    = small_ext >> sh;
    aligned[0] = aligned[0] | (|(small_ext & shift_mask));

    s2_d          = '0;
    s2_d.vld      = s1_q.vld;
    s2_d.sign     = s1_q.sign;
    s2_d.exp      = s1_q.exp;
    s2_d.spec     = s1_q.spec;
    s2_d.spec_val = s1_q.spec_val;
    s2_d.sum      = s1_q.sub ? ({1'b0, big_ext} - {1'b0, aligned})
                             : ({1'b0, big_ext} + {1'b0, aligned});
  end

  // ---------------- stage 3: normalize, round, pack ----------------
  logic [4:0]         lz;
  logic [26:0]        norm;
  logic signed [9:0]  e_norm, e_fin;
  logic               round_up;
  logic [24:0]        man_r;
  logic [22:0]        frac;

  always_comb begin
    lz = lzc27(s2_q.sum[26:0]);
    if (s2_q.sum[27]) begin
      norm   = {s2_q.sum[27:2], s2_q.sum[1] | s2_q.sum[0]};
      e_norm = $signed({2'b00, s2_q.exp}) + 10'sd1;
    end else begin
      norm   = s2_q.sum[26:0] << lz;
      e_norm = $signed({2'b00, s2_q.exp}) - $signed({5'd0, lz});
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    man_r    = {1'b0, norm[26:3]} + {24'd0, round_up};
    e_fin    = e_norm + (man_r[24] ? 10'sd1 : 10'sd0);
    frac     = man_r[24] ? 23'd0 : man_r[22:0];

    out_valid_d = s2_q.vld;
    result_d    = result_q;
    if (s2_q.vld) begin
      if (s2_q.spec)               result_d = s2_q.spec_val;
      else if (e_fin >= 10'sd255)  result_d = {s2_q.sign, 8'hFF, 23'd0};
      else if (e_fin <= 10'sd0)    result_d = {s2_q.sign, 31'd0};
      else                         result_d = {s2_q.sign, e_fin[7:0], frac};
    end
  end

  always_ff @(negedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else if (advance) begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

endmodule

// File: tb/tb_fp32_subtractor.sv
// Bench for fp32_subtractor: directed corner cases plus random traffic with backpressure,
// scored against a real-arithmetic reference.
module tb_fp32_subtractor;

  logic clk_n;
  logic rst_n;

  fp32_subtractor_if #(.WIDTH(32)) io();

  fp32_subtractor #(.WIDTH(32)) dut (
    .clk_n (clk_n),
    .rst_n (rst_n),
    .io    (io)
  );

  initial begin
    clk_n = 1'b1;
    forever #5 clk_n = ~clk_n;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int n_acc  = 0;
  int n_out  = 0;
  bit last_acc;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: exact difference in double precision, then RNE to 24 bits with flush-to-zero.
  function automatic real to_real(input logic [31:0] x);
    logic [10:0] de;
    if (x[30:23] == 8'd0) return 0.0;
    de = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], de, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] from_real(input real r);
    logic [63:0] bits;
    logic [23:0] m;
    logic [28:0] rest;
    logic [24:0] m25;
    logic        up;
    int          fe;
    bits = $realtobits(r);
    fe   = int'(bits[62:52]) - 896;
    m    = {1'b1, bits[51:29]};
    rest = bits[28:0];
    up   = (rest > 29'h1000_0000) || ((rest == 29'h1000_0000) && m[0]);
    m25  = {1'b0, m} + {24'd0, up};
    if (m25[24]) begin
      fe++;
      m25 = m25 >> 1;
    end
    if (fe >= 255) return {bits[63], 8'hFF, 23'd0};
    if (fe <= 0)   return {bits[63], 31'd0};
    return {bits[63], 8'(fe), m25[22:0]};
  endfunction

  function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    bit  a_nan, b_nan, a_inf, b_inf;
    real rr;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan) return 32'h7FC0_0000;
    if (a_inf && b_inf) return (a[31] == b[31]) ? 32'h7FC0_0000 : a;
    if (a_inf) return a;
    if (b_inf) return {~b[31], b[30:0]};
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0)
      return (a[31] && !b[31]) ? 32'h8000_0000 : 32'h0000_0000;
    rr = to_real(a) - to_real(b);
    if (rr == 0.0) return 32'h0000_0000;
    return from_real(rr);
  endfunction

  function automatic logic [31:0] pick_special(input int k);
    case (k)
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7F80_0000;
      3: return 32'hFF80_0000;
      4: return 32'h7FC0_0000;
      5: return 32'h0000_0001;
      6: return 32'h7F7F_FFFF;
      default: return 32'h3F80_0000;
    endcase
  endfunction

  task automatic gen_pair(output logic [31:0] a, output logic [31:0] b);
    int e;
    case ($urandom_range(0, 4))
      0: begin a = $urandom; b = $urandom; end
      1: begin
        e = $urandom_range(1, 250);
        a = {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
        b = {1'($urandom_range(0, 1)), 8'(e + $urandom_range(0, 3)), 23'($urandom)};
      end
      2: begin
        e = $urandom_range(1, 254);
        a = {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
        b = a ^ 32'($urandom_range(0, 15));
      end
      3: begin
        e = $urandom_range(41, 210);
        a = {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
        b = {1'($urandom_range(0, 1)), 8'(e - $urandom_range(20, 40)), 23'($urandom)};
      end
      default: begin
        a = pick_special($urandom_range(0, 7));
        b = ($urandom_range(0, 1) == 1) ? pick_special($urandom_range(0, 7)) : 32'($urandom);
      end
    endcase
  endtask

  // One clock: drive on the rising edge, observe handshakes mid-cycle, DUT acts on the falling edge.
  task automatic cycle(input bit iv, input logic [31:0] a, input logic [31:0] b, input bit ordy);
    @(posedge clk_n);
    io.in_valid  = iv;
    io.A         = a;
    io.B         = b;
    io.out_ready = ordy;
    #2;
    last_acc = io.in_valid && io.in_ready;
    if (io.out_valid && io.out_ready) begin
      n_out++;
      if (exp_q.size() > 0) check("stream_result", io.Result, exp_q.pop_front());
    end
    if (last_acc) begin
      exp_q.push_back(ref_sub(a, b));
      n_acc++;
    end
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    int n;
    bit seen;
    @(posedge clk_n);
    io.in_valid  = 1'b1;
    io.A         = a;
    io.B         = b;
    io.out_ready = 1'b1;
    @(posedge clk_n);
    io.in_valid = 1'b0;
    n    = 1;
    seen = 1'b0;
    while (!seen && n < 10) begin
      #2;
      if (io.out_valid) seen = 1'b1;
      else begin
        @(posedge clk_n);
        n++;
      end
    end
    check({tag, "_lat"}, 32'(n), 32'd3);
    check(tag, io.Result, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          pend;
    bit          saw_low;
    logic [31:0] ra, rb;
    int          issued, base, k;

    rst_n        = 1'b0;
    io.in_valid  = 1'b0;
    io.A         = '0;
    io.B         = '0;
    io.out_ready = 1'b0;
    repeat (2) @(posedge clk_n);
    #2;
    check("rst_out_valid", 32'(io.out_valid), 32'd0);
    check("rst_result", io.Result, 32'h0000_0000);
    check("rst_in_ready", 32'(io.in_ready), 32'd1);
    @(posedge clk_n);
    rst_n = 1'b1;

    run_one("basic_3m1",    32'h4040_0000, 32'h3F80_0000, 32'h4000_0000);
    run_one("equal_zero",   32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000);
    run_one("sign_add",     32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000);
    run_one("swap_neg",     32'h3F80_0000, 32'h4040_0000, 32'hC000_0000);
    run_one("tie_even",     32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000);
    run_one("exact_ulp",    32'h3F80_0000, 32'h3380_0000, 32'h3F7F_FFFF);
    run_one("inf_m_inf",    32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000);
    run_one("overflow",     32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000);
    run_one("nan_in",       32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000);
    run_one("underflow",    32'h0080_0000, 32'h0080_0001, 32'h8000_0000);
    run_one("negz_m_posz",  32'h8000_0000, 32'h0000_0000, 32'h8000_0000);
    repeat (2) cycle(1'b0, '0, '0, 1'b1);

    // Six operations with the consumer stalled on cycles 2..6.
    base    = n_out;
    issued  = 0;
    pend    = 1'b0;
    saw_low = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (!pend && issued < 6) begin
        gen_pair(ra, rb);
        pend = 1'b1;
      end
      cycle(pend, ra, rb, !(c >= 2 && c <= 6));
      if (!io.in_ready) saw_low = 1'b1;
      if (last_acc) begin
        pend = 1'b0;
        issued++;
      end
    end
    check("bp_in_ready_fell", 32'(saw_low), 32'd1);
    check("bp_out_count", 32'(n_out - base), 32'd6);

    // Random traffic with random stalls; operands held while not accepted.
    pend = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        gen_pair(ra, rb);
        pend = 1'b1;
      end
      cycle(pend, ra, rb, $urandom_range(0, 2) != 0);
      if (last_acc) pend = 1'b0;
    end
    k = 0;
    while (exp_q.size() > 0 && k < 30) begin
      cycle(1'b0, '0, '0, 1'b1);
      k++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("acc_vs_out", 32'(n_out), 32'(n_acc));

    // Reset while two operations are in flight.
    cycle(1'b1, 32'h4080_0000, 32'h3F80_0000, 1'b1);
    cycle(1'b1, 32'h4100_0000, 32'h3F80_0000, 1'b1);
    @(posedge clk_n);
    io.in_valid = 1'b0;
    rst_n       = 1'b0;
    #2;
    check("midrst_out_valid", 32'(io.out_valid), 32'd0);
    check("midrst_result", io.Result, 32'h0000_0000);
    exp_q.delete();
    @(posedge clk_n);
    rst_n = 1'b1;
    run_one("post_rst", 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000);
    base = n_out;
    repeat (6) cycle(1'b0, '0, '0, 1'b1);
    check("post_rst_extra", 32'(n_out - base), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp32_subtractor.md
# fp32_subtractor

Pipelined IEEE-754 single-precision subtractor computing Result = A − B, the inverse-operation companion to the two-stage FP32 adder in the NLA_HW datapath. It is used by the non-linear approximation engine for range reduction and residual computation (x − k·ln2, x − x0). Inputs enter through a valid/ready handshake and pass through a three-stage pipeline: unpack/swap, align/subtract, normalize/round/pack. Full throughput is one operation per cycle, with lossless backpressure.

## Interface
- WIDTH, 32, operand and result width; only 32 is supported.
- clk_n  input  1  clock; all registers update on the falling edge, matching the rest of the NLA datapath.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  A/B are valid this cycle.
- in_ready  output  1  the block accepts A/B on this edge if in_valid is high.
- A  input  WIDTH  minuend, FP32.
- B  input  WIDTH  subtrahend, FP32.
- out_valid  output  1  Result holds a completed difference.
- out_ready  input  1  downstream consumes Result on this edge if out_valid is high.
- Result  output  WIDTH  A − B, FP32.

## Operation
- Sign of B is inverted on entry; the remaining datapath is a signed-magnitude add.
- Stage 1 (unpack):
  - exp==0 is treated as zero; denormals are flushed.
  - Hidden bit is prepended.
  - Operands are swapped so that {exp,man} of Big ≥ Small.
  - Latches: expDiff = BigExp − SmallExp (8 bit), effective-op (signs differ → add), result sign = Big sign.
  - If |A| == |B| and the effective op is subtract, the zero flag is set.
- Stage 2 (align/arith):
  - Small mantissa is extended to 27 bits (24 + guard, round, sticky).
  - It is shifted right by min(expDiff, 26); shifted-out bits OR into sticky.
  - Add or subtract against Big: 28-bit result including carry.
- Stage 3 (normalize/round/pack):
  - Carry set: shift right 1, exp+1, fold the shifted bit into sticky.
  - Otherwise: 5-bit leading-zero count, shift left, exp − lzc.
  - Round to nearest, ties to even, on G/R/S. A rounding carry renormalizes with exp+1.
- Specials, resolved in stage 1 and carried as flags:
  - Any NaN, or Inf − Inf of equal sign → 0x7FC00000.
  - Inf operand → correctly signed Inf.
  - Exact zero result → +0 (0x00000000); (−0) − (+0) → 0x80000000.
- Overflow (final exp ≥ 255) → signed Inf. Underflow (final exp ≤ 0) → signed zero.
- Flow control:
  - advance = ~out_valid | out_ready; in_ready = advance.
  - On advance all three stage registers shift together, each with its valid bit; bubbles propagate as valid=0.
  - When advance is low, every stage register, including Result, holds.

## Timing
- Latency: 3 falling edges from acceptance to out_valid, with no stall.
- Throughput: 1 result per cycle while out_ready is high.
- Reset values: all stage valid bits are 0, out_valid=0, Result=0x00000000, in_ready=1 (combinational from out_valid=0).
- Reset asserted mid-operation: in-flight operations are discarded with no partial output. The first accept after rst_n deasserts produces a result 3 edges later.
- Simultaneous in_valid and a stall (out_valid=1, out_ready=0): nothing is accepted, and the upstream must hold A/B.
- Simultaneous consume and accept on the same edge is permitted; there is no bubble insertion.
- in_ready depends only on out_valid and out_ready. There is no combinational path from in_valid to in_ready.

## Test plan
- Basic: A=0x40400000 (3.0), B=0x3F800000 (1.0), out_ready=1 → Result=0x40000000 with out_valid on the 3rd falling edge. A=B=0x3F800000 → 0x00000000.
- Sign/swap: A=0x3F800000, B=0xBF800000 → 0x40000000. A=0x3F800000, B=0x40400000 → 0xC0000000.
- Rounding tie: A=0x3F800000, B=0x33000000 (2^-25) → 0x3F800000 (ties-to-even). A=0x3F800000, B=0x33800000 → 0x3F7FFFFF (exact).
- Specials:
  - 0x7F800000 − 0x7F800000 → 0x7FC00000.
  - 0x7F7FFFFF − 0xFF7FFFFF → 0x7F800000 (overflow).
  - 0x7FC00000 − 0x3F800000 → 0x7FC00000.
  - 0x00800000 − 0x00800001 → 0x80000000 (underflow flush).
- Backpressure: stream 6 random operand pairs with out_ready=0 for cycles 2–6 → in_ready falls once the pipe is full. All 6 results emerge in order, each matching a reference model, with none lost or duplicated.
- Reset mid-flight: accept 2 operations, assert rst_n low after 1 edge → out_valid=0 and Result=0 immediately. After release, a new A=0x40400000, B=0x3F800000 yields only 0x40000000.
